// File: rtl/learn_sweep_pkg.sv
// Shared types and widths for the learn-mode frequency sweep sequencer.
package learn_sweep_pkg;

  localparam int unsigned ADC_W     = 10;
  localparam int unsigned FREQ_W    = 16;
  localparam int unsigned ADDR_W    = 8;
  // Lets the frequency controller's two-stage synchroniser see learn_en rise
  localparam int unsigned ENTER_CYC = 4;

  typedef enum logic [2:0] {
    StIdle,
    StEnter,
    StSettle,
    StMeasure,
    StWrite,
    StStep,
    StExit
  } state_e;

endpackage

// File: rtl/p2p_detect.sv
// Peak-to-peak tracker over a window of valid ADC samples; flags the last sample of the window.
module p2p_detect
  import learn_sweep_pkg::*;
#(
  parameter int unsigned Samples = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [ADC_W-1:0] i_data,
  output logic [ADC_W-1:0] o_p2p,
  output logic             o_reached
);

  localparam int unsigned     CntW    = $clog2(Samples + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(Samples - 1);

  logic [ADC_W-1:0] r_max;
  logic [ADC_W-1:0] r_min;
  logic [CntW-1:0]  r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_max   <= '0;
      r_min   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_max   <= '0;
      r_min   <= '1;
      r_count <= '0;
    end else if (i_valid) begin
      if (i_data > r_max) r_max <= i_data;
      if (i_data < r_min) r_min <= i_data;
      r_count <= r_count + 1'b1;
    end
  end

  assign o_p2p     = r_max - r_min;
  // Asserted together with the final sample so the caller leaves on the same edge
  assign o_reached = i_valid && (r_count == LastCnt);

endmodule

// File: rtl/learn_sweep.sv
// Steps the frequency controller through NUM_POINTS points and records the ADC peak-to-peak
// amplitude measured at each point.
module learn_sweep
  import learn_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYC   = 1024,
  parameter int unsigned MEAS_SAMPLES = 4096,
  parameter int unsigned NUM_POINTS   = 100,
  parameter int unsigned PULSE_LEN    = 4
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  input  logic [FREQ_W-1:0] freq,
  output logic              learn_en,
  output logic              next_freq,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADC_W-1:0]  wr_amp,
  output logic [FREQ_W-1:0] wr_freq
);

  // One counter serves ENTER, SETTLE and STEP, so size it for the longest
  localparam int unsigned CntMax0 = (SETTLE_CYC > PULSE_LEN) ? SETTLE_CYC : PULSE_LEN;
  localparam int unsigned CntMax  = (CntMax0 > ENTER_CYC) ? CntMax0 : ENTER_CYC;
  localparam int unsigned CntW    = $clog2(CntMax);

  localparam logic [CntW-1:0]   EnterLast  = CntW'(ENTER_CYC - 1);
  localparam logic [CntW-1:0]   SettleLast = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0]   PulseLast  = CntW'(PULSE_LEN - 1);
  localparam logic [ADDR_W-1:0] LastIdx    = ADDR_W'(NUM_POINTS - 1);

  state_e              r_state, w_state_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic [ADDR_W-1:0]   r_index, w_index_d;
  logic [ADC_W-1:0]    w_p2p;
  logic                w_reached;
  logic                w_wr_fire;

  logic                r_learn_en, r_next_freq, r_busy, r_done, r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADC_W-1:0]    r_wr_amp;
  logic [FREQ_W-1:0]   r_wr_freq;

  p2p_detect #(
    .Samples (MEAS_SAMPLES)
  ) u_p2p (
    .i_clk     (clk_50m),
    .i_rst     (rst),
    .i_clear   (r_state == StSettle),
    .i_valid   (adc_valid && (r_state == StMeasure)),
    .i_data    (adc_data),
    .o_p2p     (w_p2p),
    .o_reached (w_reached)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_index_d = r_index;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StEnter;
          w_cnt_d   = '0;
          w_index_d = '0;
        end
      end
      StEnter: begin
        if (r_cnt == EnterLast) begin
          w_state_d = StSettle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StSettle: begin
        if (r_cnt == SettleLast) begin
          w_state_d = StMeasure;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StMeasure: begin
        if (w_reached) w_state_d = StWrite;
      end
      StWrite: begin
        if (r_index == LastIdx) begin
          w_state_d = StExit;
        end else begin
          w_state_d = StStep;
          w_index_d = r_index + 1'b1;
          w_cnt_d   = '0;
        end
      end
      StStep: begin
        if (r_cnt == PulseLast) begin
          w_state_d = StSettle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StExit:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // IDLE ignores abort so a simultaneous start wins; EXIT is already leaving
    if (abort && (r_state != StIdle) && (r_state != StExit)) begin
      w_state_d = StExit;
      w_cnt_d   = '0;
    end
  end

  assign w_wr_fire = (r_state == StWrite) && !abort;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_index     <= '0;
      r_learn_en  <= 1'b0;
      r_next_freq <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_amp    <= '0;
      r_wr_freq   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_index     <= w_index_d;
      r_learn_en  <= (w_state_d != StIdle) && (w_state_d != StExit);
      r_next_freq <= (w_state_d == StStep);
      r_busy      <= (w_state_d != StIdle);
      r_done      <= (w_state_d == StExit);
      r_wr_en     <= w_wr_fire;
      if (w_wr_fire) begin
        r_wr_addr <= r_index;
        r_wr_amp  <= w_p2p;
        r_wr_freq <= freq;
      end
    end
  end

  assign learn_en  = r_learn_en;
  assign next_freq = r_next_freq;
  assign busy      = r_busy;
  assign done      = r_done;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_amp    = r_wr_amp;
  assign wr_freq   = r_wr_freq;

endmodule
